// File: rtl/noc_pkg.sv
// Shared router encodings: port numbering and index types used across the pipeline.
// Pure declarations, no logic.
package noc_pkg;

   typedef logic [2:0] port_sel_t;

   localparam port_sel_t PORT_LOCAL = 3'd0;
   localparam port_sel_t PORT_N     = 3'd1;
   localparam port_sel_t PORT_E     = 3'd2;
   localparam port_sel_t PORT_S     = 3'd3;
   localparam port_sel_t PORT_W     = 3'd4;

   localparam int VC_IDX_W = 2;
   typedef logic [VC_IDX_W-1:0] vc_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest distance from ptr (wrapping) wins.
// Zero latency; gnt is one-hot or all zero, idx is 0 when nothing is granted.
module rr_arbiter #(
   parameter int N = 5
) (
   input  logic [N-1:0]         req,
   input  logic [$clog2(N)-1:0] ptr,
   output logic [N-1:0]         gnt,
   output logic [$clog2(N)-1:0] idx
);

   localparam int IW = $clog2(N);

   // Walk from farthest to nearest so the closest requester to ptr is written last.
   always_comb begin
      int c;
      gnt = '0;
      idx = '0;
      c   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         c = (int'(ptr) + k) % N;
         if (req[c]) begin
            gnt    = '0;
            gnt[c] = 1'b1;
            idx    = IW'(c);
         end
      end
   end

endmodule

// File: rtl/sw_alloc.sv
// Switch allocator: per-output round-robin over credit-eligible inputs, registered grants/xbar selects.
// Latency 1 cycle; backpressure is credit-based per output VC (no credit -> input not eligible).
module sw_alloc
   import noc_pkg::*;
#(
   parameter int PORT_NUM  = 5,
   parameter int VC_NUM    = 4,
   parameter int BUF_DEPTH = 4
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [PORT_NUM-1:0]                     sa_req,
   input  logic [PORT_NUM-1:0][2:0]                sa_out_port,
   input  logic [PORT_NUM-1:0][$clog2(VC_NUM)-1:0] sa_out_vc,
   input  logic [PORT_NUM-1:0]                     credit_in_valid,
   input  logic [PORT_NUM-1:0][$clog2(VC_NUM)-1:0] credit_in_vc,
   output logic [PORT_NUM-1:0]                     sa_grant,
   output logic [PORT_NUM-1:0]                     xbar_valid,
   output logic [PORT_NUM-1:0][2:0]                xbar_sel,
   output logic [PORT_NUM-1:0][VC_NUM-1:0]         credit_avail
);

   localparam int VW = $clog2(VC_NUM);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int PW = $clog2(PORT_NUM);

   logic [PORT_NUM-1:0][PW-1:0]           ptr;
   logic [PORT_NUM-1:0][VC_NUM-1:0][CW-1:0] credit;
   logic [PORT_NUM-1:0][VC_NUM-1:0][CW-1:0] credit_d;
   logic [PORT_NUM-1:0][VC_NUM-1:0]         dec;
   logic [PORT_NUM-1:0][VC_NUM-1:0]         inc;
   logic [PORT_NUM-1:0][PORT_NUM-1:0]       arb_req;
   logic [PORT_NUM-1:0][PORT_NUM-1:0]       arb_gnt;
   logic [PORT_NUM-1:0][PW-1:0]             arb_idx;
   logic [PORT_NUM-1:0]                     win_vld;
   logic [PORT_NUM-1:0][VW-1:0]             win_vc;
   logic [PORT_NUM-1:0]                     grant_d;
   logic                                    ovf;

   // Out-of-range target ports match no output, so they are dropped here.
   always_comb begin
      arb_req = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int i = 0; i < PORT_NUM; i++) begin
            if (sa_req[i] && (sa_out_port[i] == 3'(o)) && (credit[o][sa_out_vc[i]] != '0)) begin
               arb_req[o][i] = 1'b1;
            end
         end
      end
   end

   for (genvar o = 0; o < PORT_NUM; o++) begin : g_arb
      rr_arbiter #(.N(PORT_NUM)) u_arb (
         .req (arb_req[o]),
         .ptr (ptr[o]),
         .gnt (arb_gnt[o]),
         .idx (arb_idx[o])
      );
      assign win_vld[o] = |arb_gnt[o];
      assign win_vc[o]  = sa_out_vc[arb_idx[o]];
   end

   always_comb begin
      grant_d = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         grant_d = grant_d | arb_gnt[o];
      end
   end

   always_comb begin
      dec = '0;
      inc = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            dec[o][v] = win_vld[o] && (win_vc[o] == VW'(v));
            inc[o][v] = credit_in_valid[o] && (credit_in_vc[o] == VW'(v));
         end
      end
   end

   // Simultaneous grant and return cancel; a return into a full counter is held.
   always_comb begin
      credit_d = credit;
      ovf      = 1'b0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            if (dec[o][v] && !inc[o][v]) begin
               credit_d[o][v] = credit[o][v] - CW'(1);
            end else if (inc[o][v] && !dec[o][v]) begin
               if (credit[o][v] == CW'(BUF_DEPTH)) begin
                  ovf = 1'b1;
               end else begin
                  credit_d[o][v] = credit[o][v] + CW'(1);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa_grant   <= '0;
         xbar_valid <= '0;
         xbar_sel   <= '0;
         ptr        <= '0;
         for (int o = 0; o < PORT_NUM; o++) begin
            for (int v = 0; v < VC_NUM; v++) begin
               credit[o][v] <= CW'(BUF_DEPTH);
            end
         end
      end else begin
         sa_grant   <= grant_d;
         xbar_valid <= win_vld;
         credit     <= credit_d;
         for (int o = 0; o < PORT_NUM; o++) begin
            xbar_sel[o] <= port_sel_t'(arb_idx[o]);
            if (win_vld[o]) begin
               ptr[o] <= (arb_idx[o] == PW'(PORT_NUM - 1)) ? '0 : arb_idx[o] + PW'(1);
            end
         end
      end
   end

   always_comb begin
      credit_avail = '0;
      for (int o = 0; o < PORT_NUM; o++) begin
         for (int v = 0; v < VC_NUM; v++) begin
            credit_avail[o][v] = (credit[o][v] != '0);
         end
      end
   end

   // Downstream returned more credits than it has buffer slots.
   assert property (@(posedge clk) disable iff (rst) !ovf);

endmodule

// File: tb/tb_sw_alloc.sv
// Scoreboarded bench for sw_alloc: each stimulus row pushes its expected registered outputs,
// which are popped and compared one cycle later.
module tb_sw_alloc;
   import noc_pkg::*;

   typedef struct packed {
      logic [4:0]      g;
      logic [4:0]      xv;
      logic [4:0][2:0] sel;
   } exp_t;

   typedef struct packed {
      logic [4:0]      req;
      logic [4:0][2:0] port;
      logic [4:0][1:0] vc;
      logic [4:0]      civ;
      logic [4:0][1:0] civc;
      exp_t            e;
   } stim_t;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [4:0]           sa_req = '0;
   logic [4:0][2:0]      sa_out_port = '0;
   logic [4:0][1:0]      sa_out_vc = '0;
   logic [4:0]           credit_in_valid = '0;
   logic [4:0][1:0]      credit_in_vc = '0;
   logic [4:0]           sa_grant;
   logic [4:0]           xbar_valid;
   logic [4:0][2:0]      xbar_sel;
   logic [4:0][3:0]      credit_avail;

   exp_t sb[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic [19:0] all_ones = 20'hFFFFF;

   sw_alloc #(.PORT_NUM(5), .VC_NUM(4), .BUF_DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .sa_req          (sa_req),
      .sa_out_port     (sa_out_port),
      .sa_out_vc       (sa_out_vc),
      .credit_in_valid (credit_in_valid),
      .credit_in_vc    (credit_in_vc),
      .sa_grant        (sa_grant),
      .xbar_valid      (xbar_valid),
      .xbar_sel        (xbar_sel),
      .credit_avail    (credit_avail)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic stim_t s(input logic [4:0] req, input logic [14:0] port, input logic [9:0] vc,
                               input logic [4:0] civ, input logic [9:0] civc,
                               input logic [4:0] g, input logic [4:0] xv, input logic [14:0] sel);
      stim_t r;
      r.req   = req;
      r.port  = port;
      r.vc    = vc;
      r.civ   = civ;
      r.civc  = civc;
      r.e.g   = g;
      r.e.xv  = xv;
      r.e.sel = sel;
      return r;
   endfunction

   // Drive one row away from the active edge, record what it must produce, step past the edge.
   task automatic cyc(input stim_t t);
      @(negedge clk);
      sa_req          = t.req;
      sa_out_port     = t.port;
      sa_out_vc       = t.vc;
      credit_in_valid = t.civ;
      credit_in_vc    = t.civc;
      sb.push_back(t.e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if ({sa_grant, xbar_valid, xbar_sel} !== 25'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got g=%b v=%b sel=%h, want all zero", sa_grant, xbar_valid, xbar_sel);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({sa_grant, xbar_valid} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_idle: got g=%b v=%b, want 0", sa_grant, xbar_valid);
      end
      n_cmp++;
      if (credit_avail !== all_ones) begin
         n_fail++;
         $display("FAIL reset_credit_avail: got %h want %h", credit_avail, all_ones);
      end
   endtask

   task automatic test_round_robin();
      stim_t t[$];
      exp_t  e;
      logic [14:0] p3 = {PORT_LOCAL, PORT_LOCAL, PORT_E, PORT_E, PORT_E};
      logic [14:0] p2 = {PORT_LOCAL, PORT_E, PORT_LOCAL, PORT_LOCAL, PORT_E};
      t.push_back(s(5'b00111, p3, '0, '0, '0, 5'b00001, 5'b00100, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0}));
      t.push_back(s(5'b00111, p3, '0, '0, '0, 5'b00010, 5'b00100, {3'd0, 3'd0, 3'd1, 3'd0, 3'd0}));
      t.push_back(s(5'b00111, p3, '0, '0, '0, 5'b00100, 5'b00100, {3'd0, 3'd0, 3'd2, 3'd0, 3'd0}));
      t.push_back(s(5'b01001, p2, '0, '0, '0, 5'b01000, 5'b00100, {3'd0, 3'd0, 3'd3, 3'd0, 3'd0}));
      t.push_back(s(5'b01001, p2, '0, '0, '0, 5'b00000, 5'b00000, '0));
      for (int k = 0; k < 4; k++) t.push_back(s('0, '0, '0, 5'b00100, '0, '0, '0, '0));
      foreach (t[k]) begin
         cyc(t[k]);
         e = sb.pop_front();
         n_cmp++;
         if ({sa_grant, xbar_valid, xbar_sel} !== e) begin
            n_fail++;
            $display("FAIL round_robin row %0d: got g=%b v=%b sel=%h, want g=%b v=%b sel=%h",
                     k, sa_grant, xbar_valid, xbar_sel, e.g, e.xv, e.sel);
         end
         if (k == 2 || k == 4) begin
            n_cmp++;
            if (credit_avail[2][0] !== (k == 2)) begin
               n_fail++;
               $display("FAIL round_robin_credit row %0d: got avail[2][0]=%b want %b", k, credit_avail[2][0], (k == 2));
            end
         end
      end
   endtask

   task automatic test_credit_exhaust();
      stim_t t[$];
      exp_t  e;
      logic [14:0] p  = {PORT_LOCAL, PORT_N, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL};
      logic [9:0]  v  = {2'd0, 2'd2, 2'd0, 2'd0, 2'd0};
      logic [9:0]  cv = {2'd0, 2'd0, 2'd0, 2'd2, 2'd0};
      logic [14:0] sl = {3'd0, 3'd0, 3'd0, 3'd3, 3'd0};
      for (int k = 0; k < 4; k++) t.push_back(s(5'b01000, p, v, '0, '0, 5'b01000, 5'b00010, sl));
      for (int k = 0; k < 2; k++) t.push_back(s(5'b01000, p, v, '0, '0, '0, '0, '0));
      t.push_back(s(5'b01000, p, v, 5'b00010, cv, '0, '0, '0));
      t.push_back(s(5'b01000, p, v, '0, '0, 5'b01000, 5'b00010, sl));
      t.push_back(s(5'b01000, p, v, '0, '0, '0, '0, '0));
      for (int k = 0; k < 4; k++) t.push_back(s('0, '0, '0, 5'b00010, cv, '0, '0, '0));
      foreach (t[k]) begin
         cyc(t[k]);
         e = sb.pop_front();
         n_cmp++;
         if ({sa_grant, xbar_valid, xbar_sel} !== e) begin
            n_fail++;
            $display("FAIL credit_exhaust row %0d: got g=%b v=%b sel=%h, want g=%b v=%b sel=%h",
                     k, sa_grant, xbar_valid, xbar_sel, e.g, e.xv, e.sel);
         end
         if (k == 5 || k == 6) begin
            n_cmp++;
            if (credit_avail[1][2] !== (k == 6)) begin
               n_fail++;
               $display("FAIL credit_exhaust_avail row %0d: got avail[1][2]=%b want %b", k, credit_avail[1][2], (k == 6));
            end
         end
      end
   endtask

   task automatic test_same_cycle();
      stim_t t[$];
      exp_t  e;
      logic [14:0] p  = {PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_W};
      logic [9:0]  v  = {2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
      logic [9:0]  cv = {2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
      for (int k = 0; k < 2; k++) t.push_back(s(5'b00001, p, v, '0, '0, 5'b00001, 5'b10000, '0));
      t.push_back(s(5'b00001, p, v, 5'b10000, cv, 5'b00001, 5'b10000, '0));
      for (int k = 0; k < 2; k++) t.push_back(s(5'b00001, p, v, '0, '0, 5'b00001, 5'b10000, '0));
      t.push_back(s(5'b00001, p, v, '0, '0, '0, '0, '0));
      for (int k = 0; k < 4; k++) t.push_back(s('0, '0, '0, 5'b10000, cv, '0, '0, '0));
      foreach (t[k]) begin
         cyc(t[k]);
         e = sb.pop_front();
         n_cmp++;
         if ({sa_grant, xbar_valid, xbar_sel} !== e) begin
            n_fail++;
            $display("FAIL same_cycle row %0d: got g=%b v=%b sel=%h, want g=%b v=%b sel=%h",
                     k, sa_grant, xbar_valid, xbar_sel, e.g, e.xv, e.sel);
         end
         if (k == 5) begin
            n_cmp++;
            if (credit_avail[4][1] !== 1'b0) begin
               n_fail++;
               $display("FAIL same_cycle_avail: got avail[4][1]=%b want 0", credit_avail[4][1]);
            end
         end
      end
   endtask

   task automatic test_concurrent();
      stim_t t[$];
      exp_t  e;
      logic [14:0] p = {PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_S, PORT_W};
      t.push_back(s(5'b00011, p, '0, '0, '0, 5'b00011, 5'b11000, {3'd0, 3'd1, 3'd0, 3'd0, 3'd0}));
      t.push_back(s('0, '0, '0, 5'b11000, '0, '0, '0, '0));
      foreach (t[k]) begin
         cyc(t[k]);
         e = sb.pop_front();
         n_cmp++;
         if ({sa_grant, xbar_valid, xbar_sel} !== e) begin
            n_fail++;
            $display("FAIL concurrent row %0d: got g=%b v=%b sel=%h, want g=%b v=%b sel=%h",
                     k, sa_grant, xbar_valid, xbar_sel, e.g, e.xv, e.sel);
         end
      end
   endtask

   task automatic test_out_of_range();
      stim_t t[$];
      exp_t  e;
      logic [14:0] p = {3'd5, 3'd0, 3'd7, 3'd0, 3'd6};
      for (int k = 0; k < 3; k++) t.push_back(s(5'b10101, p, '0, '0, '0, '0, '0, '0));
      foreach (t[k]) begin
         cyc(t[k]);
         e = sb.pop_front();
         n_cmp++;
         if ({sa_grant, xbar_valid, xbar_sel} !== e) begin
            n_fail++;
            $display("FAIL out_of_range row %0d: got g=%b v=%b sel=%h, want none", k, sa_grant, xbar_valid, xbar_sel);
         end
      end
      n_cmp++;
      if (credit_avail !== all_ones) begin
         n_fail++;
         $display("FAIL out_of_range_credit: got %h want %h", credit_avail, all_ones);
      end
   endtask

   task automatic test_reset_mid();
      stim_t t[$];
      exp_t  e;
      logic [14:0] p = {PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_LOCAL, PORT_N};
      for (int k = 0; k < 2; k++) begin
         cyc(s(5'b00001, p, '0, '0, '0, 5'b00001, 5'b00010, '0));
         e = sb.pop_front();
         n_cmp++;
         if ({sa_grant, xbar_valid, xbar_sel} !== e) begin
            n_fail++;
            $display("FAIL reset_mid_pre row %0d: got g=%b v=%b sel=%h, want g=%b v=%b", k, sa_grant, xbar_valid, xbar_sel, e.g, e.xv);
         end
      end
      rst    = 1'b1;
      sa_req = '0;
      #1;
      n_cmp++;
      if ({sa_grant, xbar_valid, xbar_sel} !== 25'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got g=%b v=%b sel=%h, want all zero", sa_grant, xbar_valid, xbar_sel);
      end
      @(negedge clk);
      rst = 1'b0;
      n_cmp++;
      if (credit_avail !== all_ones) begin
         n_fail++;
         $display("FAIL reset_mid_avail: got %h want %h", credit_avail, all_ones);
      end
      for (int k = 0; k < 4; k++) t.push_back(s(5'b00001, p, '0, '0, '0, 5'b00001, 5'b00010, '0));
      t.push_back(s(5'b00001, p, '0, '0, '0, '0, '0, '0));
      foreach (t[k]) begin
         cyc(t[k]);
         e = sb.pop_front();
         n_cmp++;
         if ({sa_grant, xbar_valid, xbar_sel} !== e) begin
            n_fail++;
            $display("FAIL reset_mid_post row %0d: got g=%b v=%b sel=%h, want g=%b v=%b", k, sa_grant, xbar_valid, xbar_sel, e.g, e.xv);
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_credit_exhaust();
      test_same_cycle();
      test_concurrent();
      test_out_of_range();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
